mem_port_arbiter: RTL and testbench

- Arbitrates one shared block-level main memory between the instruction-cache refill port (I-side) and the data-cache refill/writeback port (D-side).
- Drives each side's BUSY_WAIT. That signal stalls the pipeline registers until the owning side's transfer has completed.
- Sits between the two caches and main memory. It is the only master on the memory interface.

---
 rtl/mem_port_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                             |
// | Description : Shares one block-level main memory between the I-cache       |
// |               refill port and the D-cache refill/writeback port. The       |
// |               arbiter is the only master on the memory interface and       |
// |               drives each requester's BUSYWAIT stall.                      |
// |                                                                            |
// | Parameters  : ADDR_W - block address width                                 |
// |               DATA_W - block data width                                    |
// |                                                                            |
// | Ports       : CLK, RESET (async, active-low)                               |
// |               I side : I_READ, I_ADDRESS -> I_READDATA, I_BUSYWAIT         |
// |               D side : D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA             |
// |                        -> D_READDATA, D_BUSYWAIT                           |
// |               Memory : MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA     |
// |                        <- MEM_READDATA, MEM_BUSYWAIT                       |
// |                                                                            |
// | Build option: MEM_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests |
// |               go to the side that was not granted last; otherwise the D    |
// |               side always wins a tie.                                      |
// |                                                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  // I-side (instruction cache refill)
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  // D-side (data cache refill / writeback)
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  // main memory
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t              state_q,     state_d;
  logic                owner_is_d_q, owner_is_d_d;  // side owning the current transfer
  logic                launch_q,    launch_d;       // first cycle of a grant
  logic                mem_read_q,  mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   i_rdata_q,   i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;

  logic                w_i_req;
  logic                w_d_req;
  logic                w_tie_d;    // 1 when D should win a simultaneous request
  logic                w_grant_i;
  logic                w_grant_d;

  // --------------------------------------------------------------------------
  // Request decode and tie-break
  // --------------------------------------------------------------------------
  assign w_i_req   = I_READ;
  assign w_d_req   = D_READ | D_WRITE;
  assign w_grant_d = w_d_req & (~w_i_req | w_tie_d);
  assign w_grant_i = w_i_req & ~w_grant_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remembers which side took the most recent grant; cleared to "I" so the
  // first tie after reset goes to D.
  logic last_d_q, last_d_d;

  always_comb begin
    last_d_d = last_d_q;
    if ((state_q == ST_IDLE) && (w_grant_d || w_grant_i)) begin
      last_d_d = w_grant_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end

  assign w_tie_d = ~last_d_q;
`else
  assign w_tie_d = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    owner_is_d_d = owner_is_d_q;
    launch_d     = launch_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (w_grant_d) begin
          state_d      = ST_GRANT_D;
          owner_is_d_d = 1'b1;
          launch_d     = 1'b1;
          mem_addr_d   = D_ADDRESS;
          // A writeback takes precedence if both D strobes are up.
          if (D_WRITE) begin
            mem_write_d = 1'b1;
            mem_wdata_d = D_WRITEDATA;
          end else begin
            mem_read_d  = 1'b1;
          end
        end else if (w_grant_i) begin
          state_d      = ST_GRANT_I;
          owner_is_d_d = 1'b0;
          launch_d     = 1'b1;
          mem_addr_d   = I_ADDRESS;
          mem_read_d   = 1'b1;
        end
      end

      ST_GRANT_I, ST_GRANT_D: begin
        // The memory has not yet seen the strobe during the launch cycle, so
        // its BUSYWAIT is meaningless there and is ignored.
        if (launch_q) begin
          launch_d = 1'b0;
        end else if (!MEM_BUSYWAIT) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) begin
            if (owner_is_d_q) begin
              d_rdata_d = MEM_READDATA;
            end else begin
              i_rdata_d = MEM_READDATA;
            end
          end
          state_d = ST_RELEASE;
        end
      end

      // One cycle in which the owner sees BUSYWAIT low and valid read data.
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      owner_is_d_q <= 1'b0;
      launch_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_is_d_q <= owner_is_d_d;
      launch_q     <= launch_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;
  assign I_READDATA    = i_rdata_q;
  assign D_READDATA    = d_rdata_q;

  // Stalls are combinational so a requester is held from the very cycle it
  // raises its request; a losing side stays stalled through the other's
  // transfer. Gated by RESET so nothing is stalled while in reset.
  assign I_BUSYWAIT = RESET & w_i_req &
                      ~((state_q == ST_RELEASE) & ~owner_is_d_q);
  assign D_BUSYWAIT = RESET & w_d_req &
                      ~((state_q == ST_RELEASE) & owner_is_d_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                          |
// | Description : Self-checking bench for mem_port_arbiter: directed steps     |
// |               followed by randomized traffic against a transaction-level   |
// |               reference model and a behavioural memory.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  localparam logic [DW-1:0] C_BEEF = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [DW-1:0] C_WR   = 128'h1234_9ABC_DEF0_1111_2222_3333_4444_5678;
  localparam logic [DW-1:0] C_WR2  = 128'hFFFF_0000_AAAA_5555_FFFF_0000_AAAA_5555;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit [2:0] EXP_TIES = 3'b101;  // D, I, D (bit 0 = first grant)
`else
  localparam bit [2:0] EXP_TIES = 3'b111;  // D always wins
`endif

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          I_READ = 1'b0;
  logic [AW-1:0] I_ADDRESS = '0;
  logic [DW-1:0] I_READDATA;
  logic          I_BUSYWAIT;
  logic          D_READ = 1'b0;
  logic          D_WRITE = 1'b0;
  logic [AW-1:0] D_ADDRESS = '0;
  logic [DW-1:0] D_WRITEDATA = '0;
  logic [DW-1:0] D_READDATA;
  logic          D_BUSYWAIT;
  logic          MEM_READ;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_ADDRESS;
  logic [DW-1:0] MEM_WRITEDATA;
  logic [DW-1:0] MEM_READDATA = '0;
  logic          MEM_BUSYWAIT = 1'b0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  // Initial memory contents: block 0x40 holds the DEAD..BEEF pattern.
  function automatic logic [DW-1:0] init_val(input int idx);
    logic [31:0] w;
    if (idx == 4) return C_BEEF;
    w = 32'hC0DE_0000 + 32'(idx);
    return {w, ~w, w, ~w};
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [3:0] n;
    n = 4'($urandom_range(0, 15));
    return {20'h0, n, 4'h0};
  endfunction

  // --------------------------------------------------------------------------
  // Behavioural memory: sees the strobe at the edge ending the launch cycle,
  // stays busy for mem_lat cycles, commits writes at completion, and drops
  // any transfer when reset is asserted.
  // --------------------------------------------------------------------------
  int            mem_lat = 0;
  logic [DW-1:0] st_data [16];
  logic [15:0]   st_written = '0;
  logic          m_active = 1'b0;
  int            m_cnt = 0;
  logic          m_wr = 1'b0;
  logic [3:0]    m_idx = '0;
  logic [DW-1:0] m_data = '0;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_active     <= 1'b0;
      m_cnt        <= 0;
      MEM_BUSYWAIT <= 1'b0;
      MEM_READDATA <= '0;
    end else if (!m_active) begin
      if (MEM_READ || MEM_WRITE) begin
        m_active     <= 1'b1;
        m_cnt        <= mem_lat;
        MEM_BUSYWAIT <= (mem_lat > 0);
        m_wr         <= MEM_WRITE;
        m_idx        <= MEM_ADDRESS[7:4];
        m_data       <= MEM_WRITEDATA;
        MEM_READDATA <= st_written[MEM_ADDRESS[7:4]] ? st_data[MEM_ADDRESS[7:4]]
                                                    : init_val(int'(MEM_ADDRESS[7:4]));
      end
    end else if (m_cnt != 0) begin
      m_cnt        <= m_cnt - 1;
      MEM_BUSYWAIT <= (m_cnt > 1);
    end else begin
      m_active <= 1'b0;
      if (m_wr) begin
        st_data[m_idx]    <= m_data;
        st_written[m_idx] <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reference model state (transaction level)
  // --------------------------------------------------------------------------
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            force_lat = -1;
  logic [DW-1:0] ref_mem [16];
  bit            in_txn = 0;
  bit            own_d = 0;
  bit            t_wr = 0;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_wdata = '0;
  int            rel_cyc = 0;
  bit            last_idle = 1;
  bit            rel_i = 0;
  bit            rel_d = 0;
  logic [DW-1:0] exp_i_rd = '0;
  logic [DW-1:0] exp_d_rd = '0;
  bit            grant_log [$];
`ifdef MEM_ARB_ROUND_ROBIN_EN
  bit            rr_last_d = 0;
`endif

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge and compare against the model.
  // Inputs are only changed right after this returns, so the values seen here
  // are the ones the DUT sampled on the preceding rising edge.
  task automatic tick();
    bit req_i, req_d, tie_d, launch, busy_cycle;
    @(negedge CLK);
    cyc++;
    rel_i = 0;
    rel_d = 0;
    if (!RESET) begin
      in_txn = 0; last_idle = 1; exp_i_rd = '0; exp_d_rd = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_last_d = 0;
`endif
      chk("rst_mem_read", MEM_READ, 0);
      chk("rst_mem_write", MEM_WRITE, 0);
      chk("rst_mem_addr", MEM_ADDRESS, 0);
      chk("rst_mem_wdata", MEM_WRITEDATA, 0);
      chk("rst_i_rdata", I_READDATA, 0);
      chk("rst_d_rdata", D_READDATA, 0);
      chk("rst_i_busy", I_BUSYWAIT, 0);
      chk("rst_d_busy", D_BUSYWAIT, 0);
      return;
    end
    req_i = I_READ;
    req_d = D_READ | D_WRITE;
    launch = 0;
    busy_cycle = in_txn;
    if (!in_txn) begin
      if (last_idle && (req_i || req_d)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        tie_d = !rr_last_d;
`else
        tie_d = 1'b1;
`endif
        launch  = 1;
        own_d   = req_d && (!req_i || tie_d);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_last_d = own_d;
`endif
        grant_log.push_back(own_d);
        t_wr    = own_d && D_WRITE;
        t_addr  = own_d ? D_ADDRESS : I_ADDRESS;
        t_wdata = D_WRITEDATA;
        mem_lat = (force_lat >= 0) ? force_lat : $urandom_range(0, 4);
        // launch, mem_lat busy cycles, one completion cycle, then release
        rel_cyc = cyc + mem_lat + 2;
        in_txn  = 1;
        chk("launch_addr", MEM_ADDRESS, t_addr);
        chk("launch_write", MEM_WRITE, t_wr);
        chk("launch_read", MEM_READ, !t_wr);
        if (t_wr) chk("launch_wdata", MEM_WRITEDATA, t_wdata);
      end else begin
        chk("idle_read", MEM_READ, 0);
        chk("idle_write", MEM_WRITE, 0);
      end
    end else if (cyc != rel_cyc) begin
      chk("hold_addr", MEM_ADDRESS, t_addr);
      chk("hold_write", MEM_WRITE, t_wr);
      chk("hold_read", MEM_READ, !t_wr);
    end else begin
      chk("rel_read", MEM_READ, 0);
      chk("rel_write", MEM_WRITE, 0);
      if (own_d) begin
        rel_d = 1;
        if (t_wr) ref_mem[t_addr[7:4]] = t_wdata;
        else      exp_d_rd = ref_mem[t_addr[7:4]];
      end else begin
        rel_i = 1;
        exp_i_rd = ref_mem[t_addr[7:4]];
      end
      in_txn = 0;
    end
    last_idle = !(busy_cycle || launch);
    chk("i_busywait", I_BUSYWAIT, req_i && !rel_i);
    chk("d_busywait", D_BUSYWAIT, req_d && !rel_d);
    chk("i_readdata", I_READDATA, exp_i_rd);
    chk("d_readdata", D_READDATA, exp_d_rd);
  endtask

  task automatic run_until_rel(input bit d_side, input int budget, output int used);
    bit seen;
    seen = 0;
    used = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      used = k + 1;
      seen = d_side ? rel_d : rel_i;
    end
    chk(d_side ? "d_release_seen" : "i_release_seen", seen, 1'b1);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && in_txn; k++) tick();
    chk("drained", in_txn, 0);
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int used;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);

    // Reset held for a few cycles.
    repeat (3) tick();
    RESET = 1'b1;
    tick();

    // Single tie: D served first, I stalled throughout, then I.
    grant_log.delete();
    force_lat = 2;
    I_READ = 1'b1; I_ADDRESS = 28'h0000080;
    D_READ = 1'b1; D_ADDRESS = 28'h00000C0;
    run_until_rel(1'b1, 20, used);
    D_READ = 1'b0;
    run_until_rel(1'b0, 20, used);
    I_READ = 1'b0;
    tick();
    chk("tie1_count", grant_log.size(), 2);
    chk("tie1_first_d", grant_log[0], 1);
    chk("tie1_second_i", grant_log[1], 0);

    // Three consecutive ties: both sides keep requesting.
    grant_log.delete();
    force_lat = 1;
    I_READ = 1'b1; I_ADDRESS = 28'h0000010;
    D_READ = 1'b1; D_ADDRESS = 28'h0000020;
    for (int g = 0; g < 3; g++) begin
      bit got;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        tick();
        got = rel_i || rel_d;
      end
      chk("tie_rel_seen", got, 1);
      if (rel_d) D_READ = 1'b0; else I_READ = 1'b0;
      tick();
      if (g < 2) begin
        I_READ = 1'b1;
        D_READ = 1'b1;
      end
    end
    I_READ = 1'b0; D_READ = 1'b0;
    drain(20);
    chk("ties_count", grant_log.size(), 3);
    for (int g = 0; g < 3; g++) chk("tie_order", grant_log[g], EXP_TIES[g]);

    // I read of 0x40 with a 5-cycle busy memory.
    force_lat = 5;
    I_READ = 1'b1; I_ADDRESS = 28'h0000040;
    run_until_rel(1'b0, 30, used);
    chk("i_rd_latency", used, 8);
    chk("i_rd_data", I_READDATA, C_BEEF);
    I_READ = 1'b0;
    tick();

    // D write of 0xA0.
    force_lat = 3;
    D_WRITE = 1'b1; D_ADDRESS = 28'h00000A0; D_WRITEDATA = C_WR;
    run_until_rel(1'b1, 30, used);
    D_WRITE = 1'b0;
    tick();
    chk("d_wr_committed", st_written[10], 1);
    chk("d_wr_data", st_data[10], C_WR);

    // Zero-wait memory: stall lifts three edges after the request edge.
    force_lat = 0;
    I_READ = 1'b1; I_ADDRESS = 28'h0000030;
    run_until_rel(1'b0, 20, used);
    chk("zero_wait_latency", used, 3);
    I_READ = 1'b0;
    tick();

    // Withdrawn D read during the launch cycle still completes.
    D_READ = 1'b1; D_ADDRESS = 28'h0000050;
    tick();
    chk("withdraw_launch", MEM_READ, 1);
    D_READ = 1'b0;
    run_until_rel(1'b1, 20, used);
    chk("withdraw_rdata", D_READDATA, init_val(5));
    tick();

    // Reset in the middle of a D write: strobe and address drop at once and
    // the write never reaches memory.
    force_lat = 8;
    D_WRITE = 1'b1; D_ADDRESS = 28'h00000A0; D_WRITEDATA = C_WR2;
    tick();
    tick();
    @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("rst_async_write", MEM_WRITE, 0);
    chk("rst_async_addr", MEM_ADDRESS, 0);
    chk("rst_async_wdata", MEM_WRITEDATA, 0);
    chk("rst_async_dbusy", D_BUSYWAIT, 0);
    D_WRITE = 1'b0;
    repeat (2) tick();
    RESET = 1'b1;
    repeat (3) tick();
    force_lat = 1;
    I_READ = 1'b1; I_ADDRESS = 28'h00000A0;
    run_until_rel(1'b0, 20, used);
    chk("rst_no_commit", I_READDATA, C_WR);
    I_READ = 1'b0;
    tick();

    // Randomized traffic from both sides.
    force_lat = -1;
    for (int n = 0; n < 600; n++) begin
      tick();
      if (rel_i) I_READ = 1'b0;
      else if (!I_READ && $urandom_range(0, 2) == 0) begin
        I_READ = 1'b1; I_ADDRESS = rand_addr();
      end else if (I_READ && $urandom_range(0, 40) == 0) I_READ = 1'b0;

      if (rel_d) begin
        D_READ = 1'b0; D_WRITE = 1'b0;
      end else if (!(D_READ || D_WRITE) && $urandom_range(0, 2) == 0) begin
        int op;
        op = $urandom_range(0, 3);
        D_READ  = (op == 0) || (op == 2);
        D_WRITE = (op != 0);
        D_ADDRESS = rand_addr();
        D_WRITEDATA = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else if ((D_READ || D_WRITE) && $urandom_range(0, 40) == 0) begin
        D_READ = 1'b0; D_WRITE = 1'b0;
      end
    end
    I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
    drain(30);
    tick();

    for (int i = 0; i < 16; i++)
      chk("final_mem", st_written[i] ? st_data[i] : init_val(i), ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
